// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit with architectural HI/LO registers (shift-add / restoring divide).
// Optional MULDIV_DIVZERO_FAST_EN: divide-by-zero completes in one cycle and adds a divZero output.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             mfReq,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
`ifdef MULDIV_DIVZERO_FAST_EN
    output logic             divZero,
`endif
    output logic [1:0]       dbgState
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state, stateNext;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;
    logic               isDiv, negQ, negR, bZero;

    // Operand decode, valid only while start is presented in IDLE.
    logic             mdStart, isSignedOp, aNeg, bNeg, fastDz;
    logic [WIDTH-1:0] aMag, bMag;

    assign mdStart    = start & ~op[2];
    assign isSignedOp = ~op[0];
    assign aNeg       = isSignedOp & opA[WIDTH-1];
    assign bNeg       = isSignedOp & opB[WIDTH-1];
    assign aMag       = aNeg ? -opA : opA;
    assign bMag       = bNeg ? -opB : opB;

`ifdef MULDIV_DIVZERO_FAST_EN
    logic dzFast;
    assign fastDz  = mdStart & op[1] & (opB == '0);
    assign divZero = done & dzFast;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)
            dzFast <= 1'b0;
        else if (state == IDLE && mdStart)
            dzFast <= fastDz;
    end
`else
    assign fastDz = 1'b0;
`endif

    assign busy     = (state != IDLE);
    assign stall    = busy & (start | mfReq);
    assign done     = (state == DONE);
    assign dbgState = state;

    // Multiply: acc = {partial product, remaining multiplier bits}, consumed LSB first.
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulStep;
    assign mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    assign mulStep = {mulSum, acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    logic [WIDTH:0]     divShift, divDiff;
    logic [2*WIDTH-1:0] divStep;
    assign divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign divDiff  = divShift - {1'b0, operand};
    assign divStep  = divDiff[WIDTH] ? {divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {divDiff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quotFix, remFix;
    assign prodFix = negQ ? -acc : acc;
    assign quotFix = bZero ? '1 : (negQ ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    assign remFix  = negR ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (mdStart) stateNext = fastDz ? DONE : RUN;
            RUN:     if (cnt == LAST) stateNext = FIX;
            FIX:     stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            acc     <= '0;
            operand <= '0;
            isDiv   <= 1'b0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
            bZero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && op == 3'd4) hi <= opA;
                    if (start && op == 3'd5) lo <= opA;
                    if (mdStart) begin
                        cnt     <= '0;
                        isDiv   <= op[1];
                        negQ    <= aNeg ^ bNeg;
                        negR    <= aNeg;
                        bZero   <= (opB == '0);
                        acc     <= op[1] ? {{WIDTH{1'b0}}, aMag} : {{WIDTH{1'b0}}, bMag};
                        operand <= op[1] ? bMag : aMag;
                        if (fastDz) begin
                            lo <= '1;
                            hi <= opA;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    acc <= isDiv ? divStep : mulStep;
                end
                FIX: begin
                    if (isDiv) begin
                        hi <= remFix;
                        lo <= quotFix;
                    end else begin
                        hi <= prodFix[2*WIDTH-1:WIDTH];
                        lo <= prodFix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed cases, hazard/stall checks, async reset and random ops
// checked by a queue-based scoreboard against a plain-arithmetic model.
module tb_muldiv_sequencer;

    localparam int W = 32;
`ifdef MULDIV_DIVZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         Reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] opA, opB;
    logic         mfReq;
    logic [W-1:0] hi, lo;
    logic         busy, stall, done;
    logic [1:0]   dbgState;
    logic         dz_act;

    int compared = 0;
    int mismatched = 0;
    logic [2*W:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .CLK(CLK), .Reset(Reset), .start(start), .op(op), .opA(opA), .opB(opB),
        .mfReq(mfReq), .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done),
`ifdef MULDIV_DIVZERO_FAST_EN
        .divZero(dz_act),
`endif
        .dbgState(dbgState)
    );

`ifndef MULDIV_DIVZERO_FAST_EN
    assign dz_act = 1'b0;
`endif

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [2*W:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        logic [W-1:0] q, r;
        logic dz;
        dz = FAST && o[1] && (b == 0);
        if (o == 3'd0) begin
            p = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
        end else if (o == 3'd1) begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        end else begin
            if (b == 0) begin
                q = '1;
                r = a;
            end else if (o == 3'd2) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    q = 32'h8000_0000;
                    r = 0;
                end else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                end
            end else begin
                q = a / b;
                r = a % b;
            end
            p = {r, q};
        end
        return {dz, p};
    endfunction

    task automatic check(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge CLK) begin
        if (Reset === 1'b0 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: got done=1 with hi=%h lo=%h required no result pending", hi, lo);
            end else begin
                logic [2*W:0] e;
                e = exp_q.pop_front();
                check("result", {dz_act, hi, lo}, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat, busy_cyc, exp_lat;
        exp_lat = (FAST && o[1] && b == 0) ? 1 : W + 2;
        @(negedge CLK);
        start = 1'b1; op = o; opA = a; opB = b;
        exp_q.push_back(model(o, a, b));
        @(negedge CLK);
        start = 1'b0; op = 3'd7;
        lat = 1;
        busy_cyc = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cyc++;
            @(negedge CLK);
            lat++;
        end
        if (busy === 1'b1) busy_cyc++;
        check("latency", lat, exp_lat);
        check("busy_cycles", busy_cyc, exp_lat);
        @(negedge CLK);
        check("busy_low_after_done", busy, 0);
    endtask

    task automatic mt_write(input logic [2:0] o, input logic [W-1:0] a);
        logic [W-1:0] hi0, lo0;
        @(negedge CLK);
        hi0 = hi; lo0 = lo;
        start = 1'b1; op = o; opA = a;
        #1 check("idle_start_no_stall", stall, 0);
        @(negedge CLK);
        start = 1'b0; op = 3'd7;
        if (o == 3'd4) check("mthi", {hi, lo}, {a, lo0});
        else if (o == 3'd5) check("mtlo", {hi, lo}, {hi0, a});
        else check("nop_unchanged", {hi, lo}, {hi0, lo0});
        check("mt_no_busy", busy, 0);
    endtask

    function automatic logic [W-1:0] rval();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'd1;
            2: return '1;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int n;
        Reset = 1'b1; start = 1'b0; op = 3'd7; opA = '0; opB = '0; mfReq = 1'b0;
        #12;
        check("reset_hilo", {hi, lo}, '0);
        check("reset_flags", {busy, stall, done, dbgState}, '0);
        @(negedge CLK);
        Reset = 1'b0;

        run_op(3'd0, 32'hFFFF_FFFD, 32'd5);
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd3, 32'd100, 32'd7);
        run_op(3'd3, 32'h0000_ABCD, 32'd0);
        run_op(3'd2, 32'hFFFF_0000, 32'd0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000);

        // Hazards during a running multiply: mfReq stalls, an MTLO is dropped.
        mfReq = 1'b0;
        #1 check("idle_mfreq_no_stall_pre", stall, 0);
        @(negedge CLK);
        start = 1'b1; op = 3'd0; opA = 32'h11; opB = 32'h22;
        exp_q.push_back(model(3'd0, 32'h11, 32'h22));
        @(negedge CLK);
        start = 1'b0; op = 3'd7; mfReq = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (n == 5) begin
                start = 1'b1; op = 3'd5; opA = 32'h1234;
            end
            #1 check("stall_while_busy", stall, 1);
            n++;
            @(negedge CLK);
            start = 1'b0; op = 3'd7;
        end
        mfReq = 1'b0;
        check("stall_cycles", n, W + 2);
        check("mtlo_ignored", lo, 32'h242);
        mt_write(3'd5, 32'h1234);
        mfReq = 1'b1;
        #1 check("idle_mfreq_no_stall", stall, 0);
        mfReq = 1'b0;
        mt_write(3'd4, 32'hCAFE_F00D);

        // Random traffic.
        for (int i = 0; i < 150; i++) begin
            logic [2:0] o;
            o = 3'($urandom_range(0, 7));
            if (o <= 3'd3) run_op(o, rval(), rval());
            else mt_write(o, $urandom());
        end

        // Asynchronous reset in RUN cycle 10, then a fresh multiply.
        mt_write(3'd4, 32'hDEAD_BEEF);
        mt_write(3'd5, 32'h0BAD_F00D);
        @(negedge CLK);
        start = 1'b1; op = 3'd0; opA = 32'd123; opB = 32'd456;
        @(negedge CLK);
        start = 1'b0; op = 3'd7;
        repeat (9) @(negedge CLK);
        #1 check("busy_before_reset", busy, 1);
        Reset = 1'b1;
        #1;
        check("async_reset_hilo", {hi, lo}, '0);
        check("async_reset_flags", {busy, done, dbgState}, '0);
        @(negedge CLK);
        Reset = 1'b0;
        run_op(3'd0, 32'd6, 32'd7);

        repeat (3) @(negedge CLK);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
